dc_link_window_monitor: RTL

- Parametrised successor to the fixed-threshold DC-link voltage classifier in the unit top level.
- Classifies ADC samples into five voltage zones, with programmable thresholds, hysteresis, N-sample debounce and a post-reset blanking window.
- Adds a sticky over-voltage trip with a clear input, plus a saturating trip counter.
- Sits between the ADC interface (volt, sample strobe) and the gate-enable/LED logic.

---
 rtl/dc_mon_pkg.sv | 21 ++
 rtl/dc_link_window_monitor_debounce.sv | 51 +++++
 rtl/dc_link_window_monitor.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dc_mon_pkg.sv
// Shared zone encoding and LED bit positions for the DC-link window monitor.
package dc_mon_pkg;

    typedef enum logic [2:0] {
        ZONE_ZERO = 3'd0,
        ZONE_UV   = 3'd1,
        ZONE_LOW  = 3'd2,
        ZONE_OK   = 3'd3,
        ZONE_OV   = 3'd4
    } zone_t;

    // Never produced by classification; stands in for "no zone accepted yet".
    localparam logic [2:0] ZONE_NONE = 3'b111;

    localparam int unsigned LED_OV   = 0;
    localparam int unsigned LED_OK   = 1;
    localparam int unsigned LED_LOW  = 2;
    localparam int unsigned LED_UV   = 3;
    localparam int unsigned LED_TRIP = 4;

endpackage

// File: rtl/dc_link_window_monitor_debounce.sv
// Pending-value debounce: accepts a new value after N consecutive agreeing valid samples.
module sample_debounce #(
    parameter int unsigned W = 3,
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid,
    input  logic [W-1:0] candidate,
    input  logic [W-1:0] current,
    output logic         accept,
    output logic [W-1:0] value
);

    localparam int unsigned CW = (N > 1) ? $clog2(N + 1) : 1;

    logic [W-1:0]  pending;
    logic          pend_v;
    logic [CW-1:0] cnt;
    logic          match;

    assign match = pend_v && (candidate == pending);
    assign value = candidate;

    always_comb begin
        accept = 1'b0;
        if (valid && (candidate != current)) begin
            accept = match ? (cnt == CW'(N - 1)) : (N == 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            pend_v  <= 1'b0;
            cnt     <= '0;
        end else if (valid) begin
            if ((candidate == current) || accept) begin
                pend_v <= 1'b0;
                cnt    <= '0;
            end else if (match) begin
                cnt <= cnt + CW'(1);
            end else begin
                pending <= candidate;
                pend_v  <= 1'b1;
                cnt     <= CW'(1);
            end
        end
    end

endmodule

// File: rtl/dc_link_window_monitor.sv
// DC-link voltage zone classifier with hysteresis, debounce, post-reset blanking
// and a sticky over-voltage trip with saturating counter.
module dc_link_window_monitor
    import dc_mon_pkg::*;
#(
    parameter int unsigned       DATA_W    = 16,
    parameter logic [DATA_W-1:0] TH_UV     = 16'h0860,
    parameter logic [DATA_W-1:0] TH_LOW    = 16'h08B0,
    parameter logic [DATA_W-1:0] TH_HIGH   = 16'h0C0C,
    parameter logic [DATA_W-1:0] HYST      = 16'h0010,
    parameter int unsigned       DEB_N     = 4,
    parameter int unsigned       BLANK_CYC = 65535,
    parameter int unsigned       TRIP_W    = 8
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] volt,
    input  logic              clear_trip,
    output logic [2:0]        zone,
    output logic              zone_valid,
    output logic              enable_out,
    output logic [4:0]        led_n,
    output logic              ov_trip,
    output logic [TRIP_W-1:0] trip_cnt
);

    localparam int unsigned BW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

    logic [BW-1:0] blank_cnt;
    logic          active;
    zone_t         zone_q;
    logic          zone_valid_q;
    zone_t         raw;
    zone_t         candidate;
    logic          up_ok;
    logic          dn_ok;
    logic [2:0]    cur_ref;
    logic          accept;
    logic [2:0]    acc_value;
    logic          ov_enter;
    logic [4:0]    led_next;

    function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

    assign active = (blank_cnt == BW'(BLANK_CYC));

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            blank_cnt <= '0;
        end else if (!active) begin
            blank_cnt <= blank_cnt + BW'(1);
        end
    end

    always_comb begin
        if (volt == '0)          raw = ZONE_ZERO;
        else if (volt <= TH_UV)  raw = ZONE_UV;
        else if (volt <= TH_LOW) raw = ZONE_LOW;
        else if (volt <= TH_HIGH) raw = ZONE_OK;
        else                     raw = ZONE_OV;
    end

    // The ZERO/UV boundary carries no hysteresis in either direction.
    always_comb begin
        up_ok = 1'b0;
        dn_ok = 1'b0;
        case (zone_q)
            ZONE_ZERO: up_ok = (volt != '0);
            ZONE_UV: begin
                up_ok = {1'b0, volt} > ({1'b0, TH_UV} + {1'b0, HYST});
                dn_ok = (volt == '0);
            end
            ZONE_LOW: begin
                up_ok = {1'b0, volt} > ({1'b0, TH_LOW} + {1'b0, HYST});
                dn_ok = volt <= sat_sub(TH_UV, HYST);
            end
            ZONE_OK: begin
                up_ok = {1'b0, volt} > ({1'b0, TH_HIGH} + {1'b0, HYST});
                dn_ok = volt <= sat_sub(TH_LOW, HYST);
            end
            ZONE_OV: dn_ok = volt <= sat_sub(TH_HIGH, HYST);
            default: ;
        endcase
        candidate = raw;
        if (zone_valid_q && !up_ok && !dn_ok) candidate = zone_q;
        cur_ref = zone_valid_q ? 3'(zone_q) : ZONE_NONE;
    end

    sample_debounce #(
        .W (3),
        .N (DEB_N)
    ) u_debounce (
        .clk       (clk),
        .rst       (sys_rst),
        .valid     (sample_valid && active),
        .candidate (candidate),
        .current   (cur_ref),
        .accept    (accept),
        .value     (acc_value)
    );

    assign ov_enter = accept && (zone_t'(acc_value) == ZONE_OV) && (zone_q != ZONE_OV);

    always_comb begin
        led_next = '1;
        if (zone_valid_q) begin
            case (zone_q)
                ZONE_OV:  led_next[LED_OV]  = 1'b0;
                ZONE_OK:  led_next[LED_OK]  = 1'b0;
                ZONE_LOW: led_next[LED_LOW] = 1'b0;
                ZONE_UV:  led_next[LED_UV]  = 1'b0;
                default:  ;
            endcase
        end
        led_next[LED_TRIP] = ~ov_trip;
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            zone_q       <= ZONE_ZERO;
            zone_valid_q <= 1'b0;
            ov_trip      <= 1'b0;
            trip_cnt     <= '0;
            enable_out   <= 1'b0;
            led_n        <= '1;
        end else begin
            if (accept) begin
                zone_q       <= zone_t'(acc_value);
                zone_valid_q <= 1'b1;
            end
            if (ov_enter) begin
                ov_trip <= 1'b1;
                if (trip_cnt != '1) trip_cnt <= trip_cnt + TRIP_W'(1);
            end else if (clear_trip && (zone_q != ZONE_OV)) begin
                ov_trip <= 1'b0;
            end
            enable_out <= zone_valid_q && (zone_q == ZONE_OK) && !ov_trip;
            led_n      <= led_next;
        end
    end

    assign zone       = zone_q;
    assign zone_valid = zone_valid_q;

endmodule
